scan_sequencer: RTL
===================

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

Interface
REQ-001 Parameter W, default 6, index width; drives the 6-to-64 one-hot decoder stage downstream.
REQ-002 Parameter DWELL, default 1, range 1..256; clock cycles each index is held on count.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 start  input  1  request a sweep; sampled only in IDLE or DONE.
REQ-006 first  input  W  first index of sweep; latched when start is accepted.
REQ-007 last  input  W  final index of sweep; latched when start is accepted.
REQ-008 dir  input  1  0 = ascending, 1 = descending; latched when start is accepted.
REQ-009 pause  input  1  freezes the sweep while high in RUN.
REQ-010 count  output  W  current index presented to the decoder.
REQ-011 valid  output  1  count is a live sweep index.
REQ-012 busy  output  1  sweep in progress; start ignored.
REQ-013 done  output  1  one-cycle pulse after the last index completes its dwell.

Function
REQ-014 States SHALL be IDLE, RUN, DONE, all outputs registered.
REQ-015 IDLE: count=0, valid=0, busy=0, done=0; start=1 SHALL move to RUN with count=first, valid=1, busy=1 on the next edge (1-cycle latency).
REQ-016 RUN: each index SHALL be held exactly DWELL unpaused cycles; dwell counter reloads on every index change.
REQ-017 RUN, dwell expired, count!=last: count SHALL step +1 (dir=0) or -1 (dir=1) modulo 2^W (63->0 ascending, 0->63 descending).
REQ-018 RUN, dwell expired, count==last: next state DONE, done=1, valid=0, busy=0, count holds last.
REQ-019 Indices emitted per sweep SHALL equal ((last-first) mod 2^W)+1 ascending, ((first-last) mod 2^W)+1 descending; first==last emits one index.
REQ-020 pause=1 in RUN SHALL freeze count and dwell counter; valid and busy stay 1; no effect in IDLE/DONE.
REQ-021 DONE SHALL last one cycle then return to IDLE with count=0; start=1 in DONE SHALL be accepted as in IDLE (back-to-back sweep, done and new first overlap by zero cycles: done cycle, then count=first).
REQ-022 start, first, last, dir changes while busy SHALL be ignored.
REQ-023 pause and dwell expiry in the same cycle: pause wins, no step.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, count=0, valid=0, busy=0, done=0, dwell counter=0, latched registers=0, regardless of state.
REQ-025 rst SHALL override start in the same cycle; a sweep interrupted by reset SHALL NOT produce done.

Structure
REQ-026 Shared package/include SHALL hold state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and default W.
REQ-027 Dwell timing SHALL be a sub-module dwell_timer (load, hold, expire) instantiated once; step/compare logic stays in scan_sequencer.

Verification
REQ-028 rst then start, first=0, last=63, dir=0, DWELL=1 -> count 0..63 on 64 consecutive cycles, valid=1 throughout, done pulse cycle 65, decoder out one-hot tracks count.
REQ-029 first=60, last=3, dir=0 -> count 60,61,62,63,0,1,2,3 then done; 8 indices.
REQ-030 first=2, last=61, dir=1, DWELL=3 -> 2,1,0,63,62,61 each held 3 cycles, done after 18 valid cycles.
REQ-031 first=last=5, pause high 4 cycles mid-dwell (DWELL=4) -> count=5 for 8 cycles, then single done.
REQ-032 rst asserted during RUN at count=10 -> next cycle count=0, valid=0, busy=0, no done; start during busy ignored.
REQ-033 start held high through DONE -> done=1 one cycle, next cycle count=first of new sweep, busy=1.

Source files
------------

// File: rtl/scan_sequencer_pkg.sv
// Shared definitions for the scan sequencer: FSM state encoding and default index width.
package scan_sequencer_pkg;

    localparam int DEFAULT_W = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/scan_sequencer_dwell_timer.sv
// Dwell timer: loads DWELL-1 on each index change, counts down while not held,
// and flags expiry when the current index has been shown for its full dwell.
module dwell_timer #(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic hold,
    output logic expire
);

    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= RELOAD;
        end else if (!hold && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    // Zero means the index has been presented DWELL times.
    assign expire = (r_cnt == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Sweeps an index from first to last (up or down, wrapping modulo 2^W), holding
// each index DWELL unpaused cycles, then pulses done for one cycle.
module scan_sequencer
    import scan_sequencer_pkg::*;
#(
    parameter int W     = DEFAULT_W,
    parameter int DWELL = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] first,
    input  logic [W-1:0] last,
    input  logic         dir,
    input  logic         pause,
    output logic [W-1:0] count,
    output logic         valid,
    output logic         busy,
    output logic         done
);

    state_t       r_state, w_state_next;
    logic [W-1:0] r_count, w_count_next;
    logic [W-1:0] r_last,  w_last_next;
    logic         r_dir,   w_dir_next;
    logic         r_valid, w_valid_next;
    logic         r_busy,  w_busy_next;
    logic         r_done,  w_done_next;
    logic         w_load, w_hold, w_expire;

    dwell_timer #(.DWELL(DWELL)) u_dwell (
        .clk    (clk),
        .rst    (rst),
        .load   (w_load),
        .hold   (w_hold),
        .expire (w_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= '0;
            r_last  <= '0;
            r_dir   <= 1'b0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
            r_last  <= w_last_next;
            r_dir   <= w_dir_next;
            r_valid <= w_valid_next;
            r_busy  <= w_busy_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_last_next  = r_last;
        w_dir_next   = r_dir;
        w_valid_next = r_valid;
        w_busy_next  = r_busy;
        w_done_next  = 1'b0;
        w_load       = 1'b0;
        w_hold       = 1'b1;

        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_state_next = RUN;
                    w_count_next = first;
                    w_last_next  = last;
                    w_dir_next   = dir;
                    w_valid_next = 1'b1;
                    w_busy_next  = 1'b1;
                    w_load       = 1'b1;
                end else begin
                    w_state_next = IDLE;
                    w_count_next = '0;
                    w_valid_next = 1'b0;
                    w_busy_next  = 1'b0;
                end
            end
            RUN: begin
                // Pause takes priority over an expiring dwell.
                if (!pause) begin
                    if (w_expire) begin
                        if (r_count == r_last) begin
                            w_state_next = DONE;
                            w_done_next  = 1'b1;
                            w_valid_next = 1'b0;
                            w_busy_next  = 1'b0;
                        end else begin
                            w_count_next = r_dir ? (r_count - W'(1)) : (r_count + W'(1));
                            w_load       = 1'b1;
                        end
                    end else begin
                        w_hold = 1'b0;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_count_next = '0;
                w_valid_next = 1'b0;
                w_busy_next  = 1'b0;
            end
        endcase
    end

    assign count = r_count;
    assign valid = r_valid;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
